// File: rtl/gbt_pattern_checker.sv
// gbt_pattern_checker
// Receive-side checker for the GBT incrementing-counter test pattern.
// Walks HUNT -> SYNC -> LOCKED on the received word stream and, once locked,
// flags and counts every frame that breaks the +1 progression.
//
// Handshake: there is no backpressure. A frame is accepted on a rising edge
// of clk_ik exactly when cen_ie=1 and rx_ready_i=1; data_i is ignored
// otherwise. rx_ready_i=0 on any edge forces the checker back to HUNT.
module gbt_pattern_checker #(
    parameter int DATA_W     = 32,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk_ik,
    input  logic              rst_ir,
    input  logic              cen_ie,
    input  logic              rx_ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              error_o,
    output logic              lock_lost_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [DATA_W-1:0] expected_o,
    output logic [1:0]        state_o
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_n;
    logic [DATA_W-1:0]   expected_q, expected_n;
    logic [GOOD_W-1:0]   good_q, good_n, good_inc;
    logic [BAD_W-1:0]    bad_q, bad_n, bad_inc;
    logic                error_q, error_n;
    logic                lock_lost_q, lock_lost_n;
    logic [CNT_W-1:0]    err_cnt_q, frame_cnt_q;
    logic                err_inc, frame_inc;
    logic                match;

    assign match    = (data_i == expected_q);
    assign good_inc = good_q + 1'b1;
    assign bad_inc  = bad_q + 1'b1;

    // Next-state, expected-value tracking and pulse generation.
    always_comb begin
        state_n     = state_q;
        expected_n  = expected_q;
        good_n      = good_q;
        bad_n       = bad_q;
        error_n     = 1'b0;
        lock_lost_n = 1'b0;
        err_inc     = 1'b0;
        frame_inc   = 1'b0;

        if (!rx_ready_i) begin
            // Link not ready: abandon any lock, counters and expected hold.
            state_n = ST_HUNT;
            good_n  = '0;
            bad_n   = '0;
            if (state_q == ST_LOCKED) begin
                lock_lost_n = 1'b1;
            end
        end else if (cen_ie) begin
            case (state_q)
                ST_HUNT: begin
                    expected_n = data_i + 1'b1;
                    good_n     = '0;
                    state_n    = ST_SYNC;
                end
                ST_SYNC: begin
                    if (match) begin
                        expected_n = expected_q + 1'b1;
                        good_n     = good_inc;
                        if (good_inc == GOOD_W'(LOCK_CNT)) begin
                            state_n = ST_LOCKED;
                            bad_n   = '0;
                        end
                    end else begin
                        // Re-seed silently; errors only count once locked.
                        expected_n = data_i + 1'b1;
                        good_n     = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: expected advances whether or not the frame matched.
                    expected_n = expected_q + 1'b1;
                    frame_inc  = 1'b1;
                    if (match) begin
                        bad_n = '0;
                    end else begin
                        error_n = 1'b1;
                        err_inc = 1'b1;
                        bad_n   = bad_inc;
                        if (bad_inc == BAD_W'(UNLOCK_CNT)) begin
                            lock_lost_n = 1'b1;
                            state_n     = ST_HUNT;
                            good_n      = '0;
                            bad_n       = '0;
                        end
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                    good_n  = '0;
                    bad_n   = '0;
                end
            endcase
        end
    end

    // State, expected value and one-cycle pulse registers.
    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            state_q     <= ST_HUNT;
            expected_q  <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            error_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            expected_q  <= expected_n;
            good_q      <= good_n;
            bad_q       <= bad_n;
            error_q     <= error_n;
            lock_lost_q <= lock_lost_n;
        end
    end

    // Saturating statistics counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else if (clear_i) begin
            err_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (frame_inc && (frame_cnt_q != {CNT_W{1'b1}})) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign locked_o    = (state_q == ST_LOCKED);
    assign error_o     = error_q;
    assign lock_lost_o = lock_lost_q;
    assign err_cnt_o   = err_cnt_q;
    assign frame_cnt_o = frame_cnt_q;
    assign expected_o  = expected_q;
    assign state_o     = state_q;

endmodule
